// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the PS/2 lines,
// decodes 11-bit frames and buffers good bytes in a small FIFO.
module ps2_receiver #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clock,
   input  logic       ps2_data,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       parity_error,
   output logic       frame_error,
   output logic       overflow
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

   logic [1:0]    clkSync_q, dataSync_q;
   logic          filtClk_q, filtClk_d, prevFilt_q;
   logic [FW-1:0] filtCnt_q, filtCnt_d;
   logic          fallStrobe, sampleBit;

   state_e        state_q, state_d;
   logic [2:0]    bitCnt_q, bitCnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parBit_q, parBit_d;
   logic [TW-1:0] toCnt_q, toCnt_d;
   logic          pushReq, parErr_d, frameErr_d;
   logic          parErr_q, frameErr_q, ovf_q;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wrPtr_q, rdPtr_q;
   logic          empty, full, push, pop;

   // Lines idle high, so everything resets to 1 to avoid a bogus edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clkSync_q  <= 2'b11;
         dataSync_q <= 2'b11;
         filtClk_q  <= 1'b1;
         prevFilt_q <= 1'b1;
         filtCnt_q  <= '0;
      end else begin
         clkSync_q  <= {clkSync_q[0], ps2_clock};
         dataSync_q <= {dataSync_q[0], ps2_data};
         filtClk_q  <= filtClk_d;
         prevFilt_q <= filtClk_q;
         filtCnt_q  <= filtCnt_d;
      end
   end

   always_comb begin
      filtClk_d = filtClk_q;
      filtCnt_d = filtCnt_q;
      if (clkSync_q[1] == filtClk_q) begin
         filtCnt_d = '0;
      end else if (filtCnt_q == FILT_MAX) begin
         filtClk_d = clkSync_q[1];
         filtCnt_d = '0;
      end else begin
         filtCnt_d = filtCnt_q + 1'b1;
      end
   end

   assign fallStrobe = prevFilt_q & ~filtClk_q;
   assign sampleBit  = dataSync_q[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         bitCnt_q   <= '0;
         shift_q    <= '0;
         parBit_q   <= 1'b0;
         toCnt_q    <= '0;
         parErr_q   <= 1'b0;
         frameErr_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitCnt_q   <= bitCnt_d;
         shift_q    <= shift_d;
         parBit_q   <= parBit_d;
         toCnt_q    <= toCnt_d;
         parErr_q   <= parErr_d;
         frameErr_q <= frameErr_d;
         ovf_q      <= pushReq & full & ~pop;
      end
   end

   // A stuck frame times out back to IDLE; a stop-bit error masks a parity error.
   always_comb begin
      state_d    = state_q;
      bitCnt_d   = bitCnt_q;
      shift_d    = shift_q;
      parBit_d   = parBit_q;
      toCnt_d    = '0;
      pushReq    = 1'b0;
      parErr_d   = 1'b0;
      frameErr_d = 1'b0;
      if (fallStrobe) begin
         case (state_q)
            IDLE: begin
               if (!sampleBit) begin
                  state_d  = DATA;
                  bitCnt_d = '0;
               end
            end
            DATA: begin
               shift_d  = {sampleBit, shift_q[7:1]};
               bitCnt_d = bitCnt_q + 1'b1;
               if (bitCnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               parBit_d = sampleBit;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (!sampleBit)                frameErr_d = 1'b1;
               else if (!(^{shift_q, parBit_q})) parErr_d = 1'b1;
               else                           pushReq    = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         if (toCnt_q == TO_MAX) begin
            state_d    = IDLE;
            frameErr_d = 1'b1;
         end else begin
            toCnt_d = toCnt_q + 1'b1;
         end
      end
   end

   assign empty = (wrPtr_q == rdPtr_q);
   assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign pop   = ~empty & ready;
   assign push  = pushReq & (~full | pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wrPtr_q[AW-1:0]] <= shift_q;
   end

   assign valid        = ~empty;
   assign data         = empty ? 8'h00 : mem[rdPtr_q[AW-1:0]];
   assign parity_error = parErr_q;
   assign frame_error  = frameErr_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: frames are bit-banged on the PS/2 lines
// with a shortened bit period and outputs are tallied on the falling clock edge.
module tb_ps2_receiver;

   localparam int HALF = 20;
   localparam int GAP  = 20;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clock = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       ready = 1'b0;
   logic       parity_error, frame_error, overflow;

   int vectors = 0;
   int miscompares = 0;
   int perrCnt = 0;
   int ferrCnt = 0;
   int ovfCnt = 0;
   logic [7:0] popQ [$];

   ps2_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(200), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
      .data(data), .valid(valid), .ready(ready),
      .parity_error(parity_error), .frame_error(frame_error), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Tally error pulses and every byte the consumer actually takes.
   always @(negedge clk) begin
      if (parity_error) perrCnt++;
      if (frame_error)  ferrCnt++;
      if (overflow)     ovfCnt++;
      if (valid && ready) popQ.push_back(data);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic oddPar(input logic [7:0] b);
      return ~(^b);
   endfunction

   task automatic clearTally();
      perrCnt = 0;
      ferrCnt = 0;
      ovfCnt  = 0;
      popQ.delete();
   endtask

   task automatic sendBit(input logic b, input logic glitch);
      ps2_data = b;
      tick(HALF / 2);
      ps2_clock = 1'b0;
      tick(HALF);
      ps2_clock = 1'b1;
      if (glitch) begin
         tick(4);
         ps2_clock = 1'b0;
         tick(3);
         ps2_clock = 1'b1;
         tick(HALF / 2 - 7);
      end else begin
         tick(HALF / 2);
      end
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic par, input logic stp, input int glitchAt);
      sendBit(1'b0, glitchAt == 0);
      for (int i = 0; i < 8; i++) sendBit(b[i], glitchAt == i + 1);
      sendBit(par, 1'b0);
      sendBit(stp, 1'b0);
      ps2_data = 1'b1;
      tick(GAP);
   endtask

   task automatic sendPartial(input logic [7:0] b, input int nBits);
      sendBit(1'b0, 1'b0);
      for (int i = 0; i < nBits; i++) sendBit(b[i], 1'b0);
      ps2_data = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick(5);
      vectors++;
      if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", valid); end
      vectors++;
      if (data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data: got %h want 00", data); end
      vectors++;
      if ({parity_error, frame_error, overflow} !== 3'b000) begin
         miscompares++; $display("[TB] FAIL reset_errors: got %b want 000", {parity_error, frame_error, overflow});
      end
      reset_n = 1'b1;
      clearTally();
      tick(30);
      vectors++;
      if (valid !== 1'b0 || ferrCnt != 0) begin
         miscompares++; $display("[TB] FAIL release_quiet: valid %b ferr %0d want 0 0", valid, ferrCnt);
      end
   endtask

   task automatic test_good_frame();
      ready = 1'b1;
      clearTally();
      sendFrame(8'h41, 1'b1, 1'b1, -1);
      vectors++;
      if (popQ.size() != 1 || popQ[0] !== 8'h41) begin
         miscompares++; $display("[TB] FAIL good_frame: got %0d bytes first %h want 1 byte 41", popQ.size(), (popQ.size() > 0) ? popQ[0] : 8'hxx);
      end
      vectors++;
      if (perrCnt != 0 || ferrCnt != 0) begin
         miscompares++; $display("[TB] FAIL good_frame_err: perr %0d ferr %0d want 0 0", perrCnt, ferrCnt);
      end
   endtask

   task automatic test_parity_error();
      clearTally();
      sendFrame(8'h41, 1'b0, 1'b1, -1);
      vectors++;
      if (perrCnt != 1 || ferrCnt != 0) begin
         miscompares++; $display("[TB] FAIL parity_error: perr %0d ferr %0d want 1 0", perrCnt, ferrCnt);
      end
      vectors++;
      if (popQ.size() != 0 || valid !== 1'b0) begin
         miscompares++; $display("[TB] FAIL parity_nopush: pops %0d valid %b want 0 0", popQ.size(), valid);
      end
   endtask

   task automatic test_stop_error();
      clearTally();
      sendFrame(8'h42, ~oddPar(8'h42), 1'b0, -1);
      vectors++;
      if (ferrCnt != 1 || perrCnt != 0 || popQ.size() != 0) begin
         miscompares++; $display("[TB] FAIL stop_error: ferr %0d perr %0d pops %0d want 1 0 0", ferrCnt, perrCnt, popQ.size());
      end
      clearTally();
      sendFrame(8'h43, oddPar(8'h43), 1'b1, -1);
      vectors++;
      if (popQ.size() != 1 || popQ[0] !== 8'h43) begin
         miscompares++; $display("[TB] FAIL after_stop_error: got %0d bytes first %h want 1 byte 43", popQ.size(), (popQ.size() > 0) ? popQ[0] : 8'hxx);
      end
   endtask

   task automatic test_timeout();
      clearTally();
      sendPartial(8'h0F, 4);
      tick(600);
      vectors++;
      if (ferrCnt != 1 || perrCnt != 0 || popQ.size() != 0) begin
         miscompares++; $display("[TB] FAIL timeout: ferr %0d perr %0d pops %0d want 1 0 0", ferrCnt, perrCnt, popQ.size());
      end
      clearTally();
      sendFrame(8'h44, oddPar(8'h44), 1'b1, -1);
      vectors++;
      if (popQ.size() != 1 || popQ[0] !== 8'h44 || ferrCnt != 0) begin
         miscompares++; $display("[TB] FAIL after_timeout: got %0d bytes first %h ferr %0d want 1 byte 44 ferr 0", popQ.size(), (popQ.size() > 0) ? popQ[0] : 8'hxx, ferrCnt);
      end
   endtask

   task automatic test_glitch();
      clearTally();
      sendFrame(8'h47, oddPar(8'h47), 1'b1, 3);
      vectors++;
      if (popQ.size() != 1 || popQ[0] !== 8'h47 || perrCnt != 0 || ferrCnt != 0) begin
         miscompares++; $display("[TB] FAIL glitch: got %0d bytes first %h perr %0d ferr %0d want 1 byte 47 no errors", popQ.size(), (popQ.size() > 0) ? popQ[0] : 8'hxx, perrCnt, ferrCnt);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] b;
      ready = 1'b0;
      clearTally();
      for (int i = 0; i < 8; i++) begin
         b = 8'h41 + 8'(i);
         sendFrame(b, oddPar(b), 1'b1, -1);
      end
      vectors++;
      if (ovfCnt != 0 || valid !== 1'b1 || data !== 8'h41) begin
         miscompares++; $display("[TB] FAIL fifo_full: ovf %0d valid %b head %h want 0 1 41", ovfCnt, valid, data);
      end
      sendFrame(8'h49, oddPar(8'h49), 1'b1, -1);
      vectors++;
      if (ovfCnt != 1 || data !== 8'h41) begin
         miscompares++; $display("[TB] FAIL overflow: ovf %0d head %h want 1 41", ovfCnt, data);
      end
      ready = 1'b1;
      tick(20);
      vectors++;
      if (popQ.size() != 8) begin
         miscompares++; $display("[TB] FAIL drain_count: got %0d want 8", popQ.size());
      end
      for (int i = 0; i < 8 && i < popQ.size(); i++) begin
         b = 8'h41 + 8'(i);
         vectors++;
         if (popQ[i] !== b) begin
            miscompares++; $display("[TB] FAIL drain_order[%0d]: got %h want %h", i, popQ[i], b);
         end
      end
      vectors++;
      if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_valid: got %b want 0", valid); end
   endtask

   task automatic test_reset_midframe();
      ready = 1'b0;
      clearTally();
      sendFrame(8'h46, oddPar(8'h46), 1'b1, -1);
      vectors++;
      if (valid !== 1'b1 || data !== 8'h46) begin
         miscompares++; $display("[TB] FAIL pre_reset_fill: valid %b data %h want 1 46", valid, data);
      end
      sendPartial(8'h05, 3);
      reset_n = 1'b0;
      tick(3);
      vectors++;
      if (valid !== 1'b0 || data !== 8'h00) begin
         miscompares++; $display("[TB] FAIL reset_flush: valid %b data %h want 0 00", valid, data);
      end
      reset_n = 1'b1;
      tick(30);
      ready = 1'b1;
      clearTally();
      sendFrame(8'h45, oddPar(8'h45), 1'b1, -1);
      vectors++;
      if (popQ.size() != 1 || popQ[0] !== 8'h45 || ferrCnt != 0 || perrCnt != 0) begin
         miscompares++; $display("[TB] FAIL after_reset: got %0d bytes first %h ferr %0d perr %0d want 1 byte 45 no errors", popQ.size(), (popQ.size() > 0) ? popQ[0] : 8'hxx, ferrCnt, perrCnt);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_parity_error();
      test_stop_error();
      test_timeout();
      test_glitch();
      test_overflow();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
